// File: rtl/lock_pkg.sv
// Shared types and constants for the password-lock control path.
package lock_pkg;

  typedef enum logic [2:0] {
    WAITING,
    EDITING,
    CHECK,
    UNLOCKED,
    ALARMING
  } state_t;

  localparam logic [1:0] CODE_WAITING  = 2'b00;
  localparam logic [1:0] CODE_EDITING  = 2'b01;
  localparam logic [1:0] CODE_UNLOCKED = 2'b10;
  localparam logic [1:0] CODE_ALARMING = 2'b11;

  localparam logic [3:0] LED_WAITING   = 4'b0001;
  localparam logic [3:0] LED_EDITING   = 4'b0011;
  localparam logic [3:0] LED_UNLOCKED  = 4'b1111;
  localparam logic [3:0] LED_ALARM_ON  = 4'b1111;

  // CHECK is internal and reports as editing.
  function automatic logic [1:0] state_code(input state_t s);
    case (s)
      WAITING:        return CODE_WAITING;
      EDITING, CHECK: return CODE_EDITING;
      UNLOCKED:       return CODE_UNLOCKED;
      ALARMING:       return CODE_ALARMING;
      default:        return CODE_WAITING;
    endcase
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-cycle sec_tick every TICK_DIV cycles.
// restart zeroes the phase so the next tick lands TICK_DIV cycles later.
module sec_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic sec_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Phase counter, wraps at TICK_DIV-1 or on restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt <= '0;
    else if (restart || cnt == CNT_LAST) cnt <= '0;
    else                                 cnt <= cnt + CNT_W'(1);
  end

  assign sec_tick = (cnt == CNT_LAST);

endmodule

// File: rtl/lock_ctrl_fsm.sv
// Central state controller of the password lock: sequencing, timeouts,
// wrong-entry counter and indicator outputs. All outputs are registered.
module lock_ctrl_fsm
  import lock_pkg::*;
#(
  parameter int TICK_DIV         = 50_000_000,
  parameter int EDIT_TIMEOUT_S   = 10,
  parameter int UNLOCK_TIMEOUT_S = 20,
  parameter int MAX_ERRORS       = 3,
  parameter int CHECK_WAIT       = 16,
  localparam int ERR_W           = $clog2(MAX_ERRORS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             edit_toggle,
  input  logic             key_activity,
  input  logic             ok_pulse,
  input  logic             admin_clear,
  input  logic             check_valid,
  input  logic             check_pass,
  output logic             check_req,
  output logic             clear_entry,
  output logic [1:0]       state_out,
  output logic [3:0]       leds,
  output logic [ERR_W-1:0] err_count,
  output logic             alarm
);

  localparam int SEC_MAX = (EDIT_TIMEOUT_S > UNLOCK_TIMEOUT_S) ? EDIT_TIMEOUT_S : UNLOCK_TIMEOUT_S;
  localparam int SEC_W   = $clog2(SEC_MAX + 1);
  localparam int CHK_W   = $clog2(CHECK_WAIT + 1);

  localparam logic [SEC_W-1:0] EDIT_LAST   = SEC_W'(EDIT_TIMEOUT_S - 1);
  localparam logic [SEC_W-1:0] UNLOCK_LAST = SEC_W'(UNLOCK_TIMEOUT_S - 1);
  localparam logic [CHK_W-1:0] CHK_LAST    = CHK_W'(CHECK_WAIT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = ERR_W'(MAX_ERRORS);

  state_t           state, nxt;
  logic             edit_q, armed, edit_edge;
  logic [SEC_W-1:0] sec;
  logic [CHK_W-1:0] chk_cnt;
  logic             sec_tick, restart;
  logic             edit_to, unlock_to, chk_to;
  logic [ERR_W-1:0] err_inc, nxt_err;
  logic             nxt_req, nxt_clr;
  logic [3:0]       nxt_leds;

  sec_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (restart),
    .sec_tick (sec_tick)
  );

  // Edit-switch edge detect; the first cycle after reset only loads the copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed  <= 1'b0;
      edit_q <= 1'b0;
    end else begin
      armed  <= 1'b1;
      edit_q <= edit_toggle;
    end
  end

  assign edit_edge = armed & (edit_toggle ^ edit_q);

  // Timer restarts on any state change and on key activity while editing.
  assign restart = (nxt != state) || (state == EDITING && key_activity);

  // Seconds since last restart, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          sec <= '0;
    else if (restart)                    sec <= '0;
    else if (sec_tick && sec != '1)      sec <= sec + SEC_W'(1);
  end

  // Cycles spent waiting for a verdict in CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                chk_cnt <= '0;
    else if (state == CHECK && nxt == CHECK)   chk_cnt <= chk_cnt + CHK_W'(1);
    else                                       chk_cnt <= '0;
  end

  assign edit_to   = sec_tick && (sec == EDIT_LAST);
  assign unlock_to = sec_tick && (sec == UNLOCK_LAST);
  assign chk_to    = (chk_cnt == CHK_LAST);
  assign err_inc   = (err_count == ERR_MAX) ? ERR_MAX : err_count + ERR_W'(1);

  // Next-state, error count and strobe decode.
  always_comb begin
    nxt     = state;
    nxt_err = err_count;
    nxt_req = 1'b0;
    nxt_clr = 1'b0;
    unique case (state)
      WAITING: begin
        if (edit_edge) begin
          nxt     = EDITING;
          nxt_clr = 1'b1;
        end
      end
      EDITING: begin
        // ok beats activity and timeout; activity (via restart) beats timeout
        if (ok_pulse) begin
          nxt     = CHECK;
          nxt_req = 1'b1;
        end else if (!key_activity && edit_to) begin
          nxt     = WAITING;
          nxt_clr = 1'b1;
        end
      end
      CHECK: begin
        if (check_valid && check_pass) begin
          nxt     = UNLOCKED;
          nxt_err = '0;
        end else if (check_valid || chk_to) begin
          nxt_clr = 1'b1;
          nxt_err = err_inc;
          nxt     = (err_inc == ERR_MAX) ? ALARMING : EDITING;
        end
      end
      UNLOCKED: begin
        if (ok_pulse || unlock_to) begin
          nxt     = WAITING;
          nxt_clr = 1'b1;
        end
      end
      ALARMING: begin
        if (admin_clear) begin
          nxt     = WAITING;
          nxt_err = '0;
        end
      end
      default: nxt = WAITING;
    endcase
    // admin clear outside alarm wipes the count and can veto an alarm entry
    if (admin_clear && state != ALARMING) begin
      nxt_err = '0;
      if (nxt == ALARMING) nxt = EDITING;
    end
  end

  // LED pattern for the upcoming state; alarm blinks on each second.
  always_comb begin
    nxt_leds = LED_WAITING;
    case (nxt)
      WAITING:        nxt_leds = LED_WAITING;
      EDITING, CHECK: nxt_leds = LED_EDITING;
      UNLOCKED:       nxt_leds = LED_UNLOCKED;
      ALARMING:       nxt_leds = (state != ALARMING) ? LED_ALARM_ON :
                                 (sec_tick ? ~leds : leds);
      default:        nxt_leds = LED_WAITING;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAITING;
      state_out   <= CODE_WAITING;
      leds        <= LED_WAITING;
      err_count   <= '0;
      alarm       <= 1'b0;
      check_req   <= 1'b0;
      clear_entry <= 1'b0;
    end else begin
      state       <= nxt;
      state_out   <= state_code(nxt);
      leds        <= nxt_leds;
      err_count   <= nxt_err;
      alarm       <= (nxt == ALARMING);
      check_req   <= nxt_req;
      clear_entry <= nxt_clr;
    end
  end

endmodule
